serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Built from a single full-subtractor cell and a registered borrow flip-flop.
- Complements the combinational full-adder cell: the subtract direction, done serially to trade area for latency.
- Sits behind a start/done handshake, so a controller or testbench can issue back-to-back operations.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range is 2 or more.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; diff/bout are valid.
- diff  output  WIDTH  result, a - b mod 2^WIDTH.
- bout  output  1  final borrow; 1 when unsigned a < b.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow FF and bit counter are cleared.
  - Asserting rst mid-operation aborts the operation immediately. No done is produced and the result is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at an edge: capture a and b into shift registers, clear borrow FF, set count=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: each edge processes bit i = count:
  - d = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d shifts into the result register from the MSB side; operand registers shift right; count increments.
  - When count = WIDTH-1 at an edge (the last bit): load diff from the final result register, load bout = br_next, go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - The next edge returns to IDLE unconditionally.
- Latency: start accepted at edge k. The last bit is processed at edge k+WIDTH, and done is high during the cycle after edge k+WIDTH.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accepting edge is k+WIDTH+2.
- start in SHIFT or DONE is ignored, not queued. Changes on a/b after the accepting edge have no effect.
- diff and bout hold their last result until the next completion. They are not cleared on start.
- busy=1 exactly while state is SHIFT or DONE.
- Counter width is $clog2(WIDTH), minimum 1. No wrap occurs, because SHIFT exits at count = WIDTH-1.
- Equal operands give diff=0, bout=0.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- When defined:
  - Adds output port ovf (1 bit), reset value 0.
  - ovf is loaded together with diff: ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), evaluated on the captured operands.
  - ovf holds with diff until the next completion.
- When undefined: no ovf port and no extra logic; all other behaviour is identical.

Test Plan:
- WIDTH=8, rst pulse then start with a=0x05, b=0x03:
  - busy rises after the accepting edge.
  - done pulses exactly 8 cycles after the accepting edge, lasting 1 cycle.
  - diff=0x02, bout=0.
- a=0x03, b=0x05 -> diff=0xFE, bout=1. a=0x00, b=0x01 -> diff=0xFF, bout=1. a=0xA5, b=0xA5 -> diff=0x00, bout=0.
- Assert start continuously for 30 cycles with a=0x10, b=0x01:
  - Operations complete every 10 cycles, each diff=0x0F.
  - Changing a/b mid-SHIFT does not alter the in-flight result.
- Start a=0x40, b=0x01, then assert rst asynchronously after 3 shift cycles:
  - busy=0, done=0, diff=0, bout=0 immediately.
  - No done pulse follows.
  - A fresh operation afterwards completes correctly.
- SERIAL_SUB_OVERFLOW_EN defined:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1.
  - a=0x7F, b=0xFF -> diff=0x80, ovf=1.
  - a=0x05, b=0x03 -> ovf=0.
- Exhaustive self-check at WIDTH=4: all 256 a/b pairs compared against a behavioural a-b model for diff and bout.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor (diff = a - b), LSB first,
// one full-subtractor cell plus a registered borrow, behind a start/done
// handshake. Optional overflow output enabled by macro SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs of the operand shift registers
  logic a_bit, b_bit, d_bit, br_nx;
  always_comb begin
    a_bit = a_q[0];
    b_bit = b_q[0];
    d_bit = a_bit ^ b_bit ^ br_q;
    br_nx = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  end

  // Next-state and datapath update for IDLE/SHIFT/DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
`endif
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_d = {d_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nx;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Counter is left at WIDTH-1 on the last bit so it never wraps
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = br_nx;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // d_bit is the result MSB on the last bit
          ovf_d   = (amsb_q != bmsb_q) && (d_bit != amsb_q);
`endif
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
    diff = diff_q;
    bout = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ovf  = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=4 instances,
// each tracked by a transaction-level model (value of a-b, done scheduled
// WIDTH edges after acceptance). Covers SERIAL_SUB_OVERFLOW_EN when defined.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       ovf8, ovf4;
`endif

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf4)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: remaining cycles until idle; 1 means the done cycle
  int         m8_cnt = 0, m4_cnt = 0;
  logic [7:0] m8_diff = '0, m8_pd = '0;
  logic [3:0] m4_diff = '0, m4_pd = '0;
  logic       m8_bout = 1'b0, m8_pb = 1'b0, m4_bout = 1'b0, m4_pb = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       m8_ovf = 1'b0, m8_po = 1'b0, m4_ovf = 1'b0, m4_po = 1'b0;
  int         sd;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8_cnt = 0; m8_diff = '0; m8_bout = 1'b0;
      m4_cnt = 0; m4_diff = '0; m4_bout = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      m8_ovf = 1'b0; m4_ovf = 1'b0;
`endif
    end else begin
      if (m8_cnt == 0) begin
        if (start8) begin
          m8_cnt = 9;
          m8_pd  = a8 - b8;
          m8_pb  = (a8 < b8);
`ifdef SERIAL_SUB_OVERFLOW_EN
          sd     = int'($signed(a8)) - int'($signed(b8));
          m8_po  = (sd > 127) || (sd < -128);
`endif
        end
      end else begin
        m8_cnt--;
        if (m8_cnt == 1) begin
          m8_diff = m8_pd; m8_bout = m8_pb;
`ifdef SERIAL_SUB_OVERFLOW_EN
          m8_ovf = m8_po;
`endif
        end
      end
      if (m4_cnt == 0) begin
        if (start4) begin
          m4_cnt = 5;
          m4_pd  = a4 - b4;
          m4_pb  = (a4 < b4);
`ifdef SERIAL_SUB_OVERFLOW_EN
          sd     = int'($signed(a4)) - int'($signed(b4));
          m4_po  = (sd > 7) || (sd < -8);
`endif
        end
      end else begin
        m4_cnt--;
        if (m4_cnt == 1) begin
          m4_diff = m4_pd; m4_bout = m4_pb;
`ifdef SERIAL_SUB_OVERFLOW_EN
          m4_ovf = m4_po;
`endif
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("busy8", 32'(busy8), 32'(m8_cnt != 0));
    chk("done8", 32'(done8), 32'(m8_cnt == 1));
    chk("diff8", 32'(diff8), 32'(m8_diff));
    chk("bout8", 32'(bout8), 32'(m8_bout));
    chk("busy4", 32'(busy4), 32'(m4_cnt != 0));
    chk("done4", 32'(done4), 32'(m4_cnt == 1));
    chk("diff4", 32'(diff4), 32'(m4_diff));
    chk("bout4", 32'(bout4), 32'(m4_bout));
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf8", 32'(ovf8), 32'(m8_ovf));
    chk("ovf4", 32'(ovf4), 32'(m4_ovf));
`endif
  end

  // One WIDTH=8 operation from idle; returns result and accept-to-done latency
  task automatic run8(input logic [7:0] xa, input logic [7:0] xb,
                      output logic [7:0] d, output logic bo, output int lat);
    a8 = xa; b8 = xb; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("busy8_after_accept", 32'(busy8), 32'd1);
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done8_seen", 32'(done8), 32'd1);
    d = diff8; bo = bout8;
    @(posedge clk); #1;
    chk("done8_one_cycle", 32'(done8), 32'd0);
  endtask

  task automatic run4(input logic [3:0] xa, input logic [3:0] xb,
                      output logic [3:0] d, output logic bo, output int lat);
    a4 = xa; b4 = xb; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done4_seen", 32'(done4), 32'd1);
    d = diff4; bo = bout4;
    @(posedge clk); #1;
  endtask

  logic [7:0] d8;
  logic [3:0] d4;
  logic       bo;
  int         lat, ndone, last_done, gap;

  initial begin
    #1;
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_diff8", 32'(diff8), 32'd0);
    chk("rst_bout8", 32'(bout8), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run8(8'h05, 8'h03, d8, bo, lat);
    chk("lat_05_03", 32'(lat), 32'd8);
    chk("diff_05_03", 32'(d8), 32'h02);
    chk("bout_05_03", 32'(bo), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf_05_03", 32'(ovf8), 32'd0);
`endif
    run8(8'hA5, 8'hA5, d8, bo, lat);
    chk("diff_A5_A5", 32'(d8), 32'h00);
    chk("bout_A5_A5", 32'(bo), 32'd0);
    run8(8'h03, 8'h05, d8, bo, lat);
    chk("diff_03_05", 32'(d8), 32'hFE);
    chk("bout_03_05", 32'(bo), 32'd1);
`ifdef SERIAL_SUB_OVERFLOW_EN
    run8(8'h80, 8'h01, d8, bo, lat);
    chk("diff_80_01", 32'(d8), 32'h7F);
    chk("ovf_80_01", 32'(ovf8), 32'd1);
    run8(8'h7F, 8'hFF, d8, bo, lat);
    chk("diff_7F_FF", 32'(d8), 32'h80);
    chk("ovf_7F_FF", 32'(ovf8), 32'd1);
`endif
    run8(8'h00, 8'h01, d8, bo, lat);
    chk("diff_00_01", 32'(d8), 32'hFF);
    chk("bout_00_01", 32'(bo), 32'd1);

    // start held for 30 cycles; operands scrambled except when an accept is due
    ndone = 0; last_done = -1;
    for (int i = 0; i < 30; i++) begin
      start8 = 1'b1;
      if (m8_cnt == 0) begin
        a8 = 8'h10; b8 = 8'h01;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
      @(posedge clk); #1;
      if (done8) begin
        chk("cont_diff", 32'(diff8), 32'h0F);
        if (last_done >= 0) begin
          gap = i - last_done;
          chk("cont_period", 32'(gap), 32'd10);
        end
        last_done = i;
        ndone++;
      end
    end
    start8 = 1'b0;
    chk("cont_count", 32'(ndone), 32'd3);

    // Abort mid-operation with asynchronous reset
    a8 = 8'h40; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_diff", 32'(diff8), 32'd0);
    chk("abort_bout", 32'(bout8), 32'd0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run8(8'h40, 8'h01, d8, bo, lat);
    chk("diff_after_abort", 32'(d8), 32'h3F);
    chk("bout_after_abort", 32'(bo), 32'd0);
    chk("lat_after_abort", 32'(lat), 32'd8);

    // Exhaustive WIDTH=4 check against plain arithmetic
    for (int unsigned x = 0; x < 16; x++) begin
      for (int unsigned y = 0; y < 16; y++) begin
        run4(4'(x), 4'(y), d4, bo, lat);
        chk("ex4_diff", 32'(d4), (x - y) & 32'hF);
        chk("ex4_bout", 32'(bo), 32'(x < y));
        chk("ex4_lat", 32'(lat), 32'd4);
      end
    end

    // Random start/operand traffic on the WIDTH=8 instance
    for (int i = 0; i < 1500; i++) begin
      start8 = ($urandom_range(0, 2) == 0);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
